seg7_scan_ctrl: RTL and testbench

//  Parametrised multiplexed 7-segment scan controller: time-slices NUM_DIGITS hex digits onto one

---
 rtl/seg7_pkg.sv | 29 ++
 rtl/hex7seg_decoder.sv | 43 ++++
 rtl/seg7_scan_ctrl.sv | 151 +++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
//   Shared constants for the 7-segment scan controller.
//   Segment codes are ordered {a,b,c,d,e,f,g,dp}, active-low (0 = segment lit).
// ---------------------------------------------------------------------------
package seg7_pkg;

  localparam logic [7:0] SEG_0   = 8'h03;
  localparam logic [7:0] SEG_1   = 8'h9F;
  localparam logic [7:0] SEG_2   = 8'h25;
  localparam logic [7:0] SEG_3   = 8'h0D;
  localparam logic [7:0] SEG_4   = 8'h99;
  localparam logic [7:0] SEG_5   = 8'h49;
  localparam logic [7:0] SEG_6   = 8'h41;
  localparam logic [7:0] SEG_7   = 8'h1F;
  localparam logic [7:0] SEG_8   = 8'h01;
  localparam logic [7:0] SEG_9   = 8'h19;
  localparam logic [7:0] SEG_A   = 8'h11;
  localparam logic [7:0] SEG_B   = 8'hC1;
  localparam logic [7:0] SEG_C   = 8'h63;
  localparam logic [7:0] SEG_D   = 8'h85;
  localparam logic [7:0] SEG_E   = 8'h61;
  localparam logic [7:0] SEG_F   = 8'h71;
  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Bit position of the decimal point inside a segment code.
  localparam int SEG_DP_BIT = 0;

endpackage : seg7_pkg

// File: rtl/hex7seg_decoder.sv
// ---------------------------------------------------------------------------
// hex7seg_decoder
//   Combinational hex-digit to 7-segment decoder, active-low outputs.
// Ports
//   nibble  in  4   hex value 0..F
//   dp      in  1   1 = light the decimal point
//   seg     out 8   {a,b,c,d,e,f,g,dp}, 0 = lit
// ---------------------------------------------------------------------------
module hex7seg_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    unique case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_OFF;
    endcase
    if (dp) begin
      seg[SEG_DP_BIT] = 1'b0;
    end
  end

endmodule : hex7seg_decoder

// File: rtl/seg7_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg7_scan_ctrl
//   Multiplexed 7-segment scan controller. Time-slices NUM_DIGITS hex digits
//   onto one shared active-low segment bus with per-digit decimal point and
//   blanking, PWM brightness and a frame-done pulse. All outputs registered.
// Ports
//   clk         in   1             system clock, rising edge
//   rst_n       in   1             synchronous reset, active-low
//   en          in   1             run enable; low = display off, state cleared
//   display     in   4*NUM_DIGITS  hex digits, digit i = display[4*i +: 4]
//   dp          in   NUM_DIGITS    decimal point per digit, 1 = lit
//   blank       in   NUM_DIGITS    1 = digit dark
//   brightness  in   DIM_WIDTH     duty code; 0 = off, all-ones = full on
//   led_en      out  NUM_DIGITS    digit select, active-low
//   led_cx      out  8             segments {a..g,dp}, active-low
//   frame_done  out  1             1-cycle pulse when the scan wraps to digit 0
// ---------------------------------------------------------------------------
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS      = 8,
  parameter int TICKS_PER_DIGIT = 25000,
  parameter int CNT_WIDTH       = 16,
  parameter int DIM_WIDTH       = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] display,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic [DIM_WIDTH-1:0]    brightness,
  output logic [NUM_DIGITS-1:0]   led_en,
  output logic [7:0]              led_cx,
  output logic                    frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_WIDTH-1:0] TICK_LAST = CNT_WIDTH'(TICKS_PER_DIGIT - 1);
  localparam logic [IDX_W-1:0]     IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [DIM_WIDTH-1:0] DIM_FULL  = '1;

  if (TICKS_PER_DIGIT < 2 || (TICKS_PER_DIGIT >> CNT_WIDTH) != 0) begin : g_bad_ticks
    $error("seg7_scan_ctrl: TICKS_PER_DIGIT must be >= 2 and fit in CNT_WIDTH bits");
  end
  if (NUM_DIGITS < 1 || NUM_DIGITS > 16) begin : g_bad_digits
    $error("seg7_scan_ctrl: NUM_DIGITS must be 1..16");
  end

  logic                  running_q, running_d;
  logic [CNT_WIDTH-1:0]  presc_q, presc_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DIM_WIDTH-1:0]  pwm_q, pwm_d;
  logic [3:0]            nib_q, nib_d;
  logic                  dp_q, dp_d;
  logic                  blank_q, blank_d;
  logic [NUM_DIGITS-1:0] led_en_q, led_en_d;
  logic [7:0]            led_cx_q, led_cx_d;
  logic                  frame_done_q, frame_done_d;

  logic                  tick;
  logic                  slot_load;
  logic                  lit_d;
  logic                  drive_d;
  logic [NUM_DIGITS-1:0] sel_d;
  logic [7:0]            code_d;

  assign tick      = running_q && (presc_q == TICK_LAST);
  assign slot_load = en && (!running_q || tick);

  // Outputs are computed from next-state slot values so that select and
  // segments change on the very edge that loads a new slot.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_sel
    assign sel_d[gi] = (idx_d == IDX_W'(gi));
  end

  hex7seg_decoder u_dec (
    .nibble (nib_d),
    .dp     (dp_d),
    .seg    (code_d)
  );

  always_comb begin
    running_d    = en;
    frame_done_d = 1'b0;
    presc_d      = presc_q + 1'b1;
    idx_d        = idx_q;
    pwm_d        = pwm_q + 1'b1;   // wraps naturally at 2**DIM_WIDTH
    nib_d        = nib_q;
    dp_d         = dp_q;
    blank_d      = blank_q;

    if (!en || !running_q) begin
      // Disabled, or first enabled edge: everything restarts at digit 0.
      presc_d = '0;
      idx_d   = '0;
      pwm_d   = '0;
    end else if (tick) begin
      presc_d      = '0;
      pwm_d        = '0;
      idx_d        = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      frame_done_d = (idx_q == IDX_LAST);
    end

    if (!en) begin
      nib_d   = '0;
      dp_d    = 1'b0;
      blank_d = 1'b0;
    end else if (slot_load) begin
      nib_d   = display[4*idx_d +: 4];
      dp_d    = dp[idx_d];
      blank_d = blank[idx_d];
    end

    lit_d    = (brightness == DIM_FULL) || (pwm_d < brightness);
    drive_d  = en && lit_d && !blank_d;
    led_en_d = drive_d ? ~sel_d : '1;
    led_cx_d = drive_d ? code_d : SEG_OFF;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      running_q    <= 1'b0;
      presc_q      <= '0;
      idx_q        <= '0;
      pwm_q        <= '0;
      nib_q        <= '0;
      dp_q         <= 1'b0;
      blank_q      <= 1'b0;
      led_en_q     <= '1;
      led_cx_q     <= SEG_OFF;
      frame_done_q <= 1'b0;
    end else begin
      running_q    <= running_d;
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      pwm_q        <= pwm_d;
      nib_q        <= nib_d;
      dp_q         <= dp_d;
      blank_q      <= blank_d;
      led_en_q     <= led_en_d;
      led_cx_q     <= led_cx_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign led_en     = led_en_q;
  assign led_cx     = led_cx_q;
  assign frame_done = frame_done_q;

endmodule : seg7_scan_ctrl

// File: tb/tb_seg7_scan_ctrl.sv
module tb_seg7_scan_ctrl;

  localparam int ND = 5;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [19:0] display;
  logic [4:0]  dp;
  logic [4:0]  blank;
  logic [3:0]  brightness;

  logic [4:0]  led_en_a, led_en_b;
  logic [7:0]  led_cx_a, led_cx_b;
  logic        fd_a, fd_b;

  seg7_scan_ctrl #(.NUM_DIGITS(ND), .TICKS_PER_DIGIT(4), .CNT_WIDTH(16), .DIM_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .display(display), .dp(dp), .blank(blank),
    .brightness(brightness), .led_en(led_en_a), .led_cx(led_cx_a), .frame_done(fd_a)
  );

  seg7_scan_ctrl #(.NUM_DIGITS(ND), .TICKS_PER_DIGIT(32), .CNT_WIDTH(16), .DIM_WIDTH(4)) dut32 (
    .clk(clk), .rst_n(rst_n), .en(en), .display(display), .dp(dp), .blank(blank),
    .brightness(brightness), .led_en(led_en_b), .led_cx(led_cx_b), .frame_done(fd_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference segment table written straight from the digit shapes.
  logic [7:0] seg_tab [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                               8'h01, 8'h19, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

  // Behavioural model: time since start determines the slot, the digit and
  // the PWM phase; inputs are snapshotted at each slot boundary.
  int         mt   [2] = '{4, 32};
  int         mk   [2] = '{-1, -1};
  int         mdig [2];
  logic [7:0] mcode[2];
  logic       mblnk[2];
  logic [4:0] exp_en[2];
  logic [7:0] exp_cx[2];
  logic       exp_fd[2];

  task automatic model_step(input int m);
    int ph;
    int pwm;
    bit lit;
    logic [3:0] nib;
    if (!rst_n || !en) begin
      mk[m] = -1; exp_en[m] = 5'h1F; exp_cx[m] = 8'hFF; exp_fd[m] = 1'b0;
      return;
    end
    mk[m]++;
    ph = mk[m] % mt[m];
    if (ph == 0) begin
      mdig[m]  = (mk[m] / mt[m]) % ND;
      nib      = display[4*mdig[m] +: 4];
      mcode[m] = seg_tab[nib] & (dp[mdig[m]] ? 8'hFE : 8'hFF);
      mblnk[m] = blank[mdig[m]];
    end
    exp_fd[m] = (mk[m] > 0) && (ph == 0) && (mdig[m] == 0);
    pwm = ph % 16;
    lit = (brightness == 4'hF) || (pwm < int'(brightness));
    if (lit && !mblnk[m]) begin
      exp_en[m] = ~(5'b00001 << mdig[m]);
      exp_cx[m] = mcode[m];
    end else begin
      exp_en[m] = 5'h1F;
      exp_cx[m] = 8'hFF;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
    check_eq("a_led_en", 32'(led_en_a), 32'(exp_en[0]));
    check_eq("a_led_cx", 32'(led_cx_a), 32'(exp_cx[0]));
    check_eq("a_frame_done", 32'(fd_a), 32'(exp_fd[0]));
    check_eq("b_led_en", 32'(led_en_b), 32'(exp_en[1]));
    check_eq("b_led_cx", 32'(led_cx_b), 32'(exp_cx[1]));
    check_eq("b_frame_done", 32'(fd_b), 32'(exp_fd[1]));
  endtask

  task automatic restart();
    en = 1'b0;
    cycle();
    en = 1'b1;
    cycle();
  endtask

  logic [4:0] en_seq [5] = '{5'b11110, 5'b11101, 5'b11011, 5'b10111, 5'b01111};
  logic [7:0] cx_seq [5] = '{8'h03, 8'h63, 8'h0D, 8'h11, 8'h19};

  initial begin
    int lit_cnt;
    rst_n = 1'b0; en = 1'b0; display = 20'h9A3C0; dp = '0; blank = '0; brightness = 4'hF;

    // 1: reset and start
    repeat (3) begin
      cycle();
      check_eq("t1_rst_en", 32'(led_en_a), 32'h1F);
      check_eq("t1_rst_cx", 32'(led_cx_a), 32'hFF);
    end
    rst_n = 1'b1; en = 1'b1;
    cycle();
    check_eq("t1_start_en", 32'(led_en_a), 32'(5'b11110));
    check_eq("t1_start_cx", 32'(led_cx_a), 32'h03);

    // 2: scan and wrap
    for (int j = 1; j <= 20; j++) begin
      cycle();
      check_eq("t2_en", 32'(led_en_a), 32'(en_seq[(j/4)%5]));
      check_eq("t2_cx", 32'(led_cx_a), 32'(cx_seq[(j/4)%5]));
      check_eq("t2_fd", 32'(fd_a), (j == 20) ? 32'd1 : 32'd0);
    end

    // 3: decimal point and blanking
    dp = 5'b00010; blank = 5'b00100;
    restart();
    repeat (4) cycle();
    check_eq("t3_dp_en", 32'(led_en_a), 32'(5'b11101));
    check_eq("t3_dp_cx", 32'(led_cx_a), 32'h62);
    repeat (4) cycle();
    check_eq("t3_blank_en", 32'(led_en_a), 32'h1F);
    check_eq("t3_blank_cx", 32'(led_cx_a), 32'hFF);

    // 4: brightness duty on the long-slot instance
    dp = '0; blank = '0; brightness = 4'd4;
    restart();
    lit_cnt = (led_en_b != 5'h1F) ? 1 : 0;
    repeat (15) begin
      cycle();
      if (led_en_b != 5'h1F) lit_cnt++;
    end
    check_eq("t4_duty4", 32'(lit_cnt), 32'd4);
    brightness = 4'd0;
    restart();
    lit_cnt = 0;
    repeat (32) begin
      cycle();
      if (led_en_b != 5'h1F || led_cx_b != 8'hFF) lit_cnt++;
    end
    check_eq("t4_duty0", 32'(lit_cnt), 32'd0);

    // 5: mid-slot input change, disable and re-enable
    brightness = 4'hF;
    restart();
    cycle();
    display = 20'h12345;
    cycle();
    check_eq("t5_hold_cx", 32'(led_cx_a), 32'h03);
    cycle();
    check_eq("t5_hold_cx2", 32'(led_cx_a), 32'h03);
    cycle();
    check_eq("t5_next_cx", 32'(led_cx_a), 32'h99);
    cycle();
    en = 1'b0;
    cycle();
    check_eq("t5_off_en", 32'(led_en_a), 32'h1F);
    check_eq("t5_off_cx", 32'(led_cx_a), 32'hFF);
    check_eq("t5_off_fd", 32'(fd_a), 32'd0);
    en = 1'b1;
    cycle();
    check_eq("t5_re_en", 32'(led_en_a), 32'(5'b11110));
    check_eq("t5_re_cx", 32'(led_cx_a), 32'h49);

    // 6: reset is only sampled at the clock edge
    cycle();
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    cycle();
    check_eq("t6_glitch_en", 32'(led_en_a), 32'(5'b11110));
    check_eq("t6_glitch_cx", 32'(led_cx_a), 32'h49);
    rst_n = 1'b0;
    cycle();
    check_eq("t6_rst_en", 32'(led_en_a), 32'h1F);
    check_eq("t6_rst_cx", 32'(led_cx_a), 32'hFF);
    rst_n = 1'b1;

    // Randomized run against the model
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 59) == 0) en = ~en;
      rst_n = ($urandom_range(0, 249) == 0) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 5) == 0) display = 20'($urandom);
      if ($urandom_range(0, 9) == 0) dp = 5'($urandom);
      if ($urandom_range(0, 9) == 0) blank = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'b0;
      if ($urandom_range(0, 39) == 0) brightness = 4'($urandom);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_seg7_scan_ctrl
